// File: rtl/bitbakery_pkg.sv
// Shared constants and helpers for the bitbakery input conditioner.
package bitbakery_pkg;

    localparam int unsigned N_BOTOES            = 7;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned REPEAT_CYCLES       = 500;
    localparam int unsigned REPEAT_W            = 16;

    localparam logic [N_BOTOES-1:0] JOGADA_NENHUMA = '0;

    localparam int unsigned BOTAO_0 = 0;
    localparam int unsigned BOTAO_1 = 1;
    localparam int unsigned BOTAO_2 = 2;
    localparam int unsigned BOTAO_3 = 3;
    localparam int unsigned BOTAO_4 = 4;
    localparam int unsigned BOTAO_5 = 5;
    localparam int unsigned BOTAO_6 = 6;

    function automatic int unsigned popcount(input logic [N_BOTOES-1:0] v);
        int unsigned c;
        c = '0;
        for (int i = 0; i < N_BOTOES; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/bitbakery_debouncer.sv
// One raw active-low input: synchroniser, debounce counter, stable level and press detect.
module bitbakery_debouncer
    import bitbakery_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic raw_n_in,
    output logic stable,
    output logic stable_next_c,
    output logic rise_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   synced_c;

    assign synced_c = ~sync_q[SYNC_STAGES-1];

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_n_in};
        cnt_d    = '0;
        stable_d = stable_q;
        if (synced_c != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = synced_c;
            else                                      cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable        = stable_q;
    assign stable_next_c = stable_d;
    assign rise_c        = stable_d & ~stable_q;

endmodule

// File: rtl/bitbakery_input_conditioner.sv
// Conditions raw board buttons into one-hot play events and a start pulse.
// Optional auto-repeat of a held play is enabled by defining BITBAKERY_AUTOREPEAT_EN.
module bitbakery_input_conditioner
    import bitbakery_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic [N_BOTOES-1:0] botoes_in,
    input  logic                iniciar_in,
    input  logic                enable,
    input  logic                clear_jogada,
    output logic [N_BOTOES-1:0] jogada_out,
    output logic                jogada_valid,
    output logic                multi_press,
    output logic                iniciar_pulse,
    output logic [N_BOTOES-1:0] botoes_estaveis
);

    logic [N_BOTOES:0]   raw_n, stable_all, stable_next_all, rise_all;
    logic [N_BOTOES-1:0] press_c, btn_next_c;
    logic                accept_c, multi_c, unused_ini_c;

    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                jogada_valid_q, jogada_valid_d;
    logic                multi_press_q, multi_press_d;
    logic                iniciar_pulse_q, iniciar_pulse_d;

    // Bit N_BOTOES carries the start button.
    assign raw_n = {iniciar_in, botoes_in};

    for (genvar i = 0; i < N_BOTOES + 1; i++) begin : g_deb
        bitbakery_debouncer #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock_in     (clock_in),
            .reset_in     (reset_in),
            .raw_n_in     (raw_n[i]),
            .stable       (stable_all[i]),
            .stable_next_c(stable_next_all[i]),
            .rise_c       (rise_all[i])
        );
    end

    assign press_c      = rise_all[N_BOTOES-1:0];
    assign btn_next_c   = stable_next_all[N_BOTOES-1:0];
    assign unused_ini_c = stable_all[N_BOTOES] ^ stable_next_all[N_BOTOES];

    // A lone new press with nothing else held is a play; any overlap is rejected.
    assign accept_c = enable && (press_c != '0) && (popcount(btn_next_c) == 32'd1);
    assign multi_c  = enable && (press_c != '0) && (popcount(btn_next_c) > 32'd1);

`ifdef BITBAKERY_AUTOREPEAT_EN
    logic [REPEAT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic                rep_armed_q, rep_armed_d;
    logic                rep_fire_c;

    // Re-fire only while the accepted button alone stays held and play is enabled.
    always_comb begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
        rep_fire_c  = 1'b0;
        if (accept_c) begin
            rep_armed_d = 1'b1;
        end else if (rep_armed_q && enable && !clear_jogada && (btn_next_c == jogada_q)) begin
            rep_armed_d = 1'b1;
            if (rep_cnt_q == REPEAT_W'(REPEAT_CYCLES - 1)) rep_fire_c = 1'b1;
            else                                           rep_cnt_d  = rep_cnt_q + REPEAT_W'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`endif

    always_comb begin
        jogada_d        = jogada_q;
        jogada_valid_d  = accept_c;
        multi_press_d   = multi_c;
        iniciar_pulse_d = rise_all[N_BOTOES];
        if (clear_jogada) jogada_d = JOGADA_NENHUMA;
        if (accept_c)     jogada_d = press_c;
`ifdef BITBAKERY_AUTOREPEAT_EN
        if (rep_fire_c)   jogada_valid_d = 1'b1;
`endif
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            jogada_q        <= JOGADA_NENHUMA;
            jogada_valid_q  <= 1'b0;
            multi_press_q   <= 1'b0;
            iniciar_pulse_q <= 1'b0;
        end else begin
            jogada_q        <= jogada_d;
            jogada_valid_q  <= jogada_valid_d;
            multi_press_q   <= multi_press_d;
            iniciar_pulse_q <= iniciar_pulse_d;
        end
    end

    assign jogada_out      = jogada_q;
    assign jogada_valid    = jogada_valid_q;
    assign multi_press     = multi_press_q;
    assign iniciar_pulse   = iniciar_pulse_q;
    assign botoes_estaveis = stable_all[N_BOTOES-1:0];

endmodule

// File: tb/tb_bitbakery_input_conditioner.sv
// Scoreboard bench for bitbakery_input_conditioner: expected pulses queued at stimulus time.
module tb_bitbakery_input_conditioner;
    import bitbakery_pkg::*;

    localparam int LAT      = 6;
    localparam int EV_VALID = 0;
    localparam int EV_MULTI = 1;
    localparam int EV_INI   = 2;

    typedef struct {
        int                  kind;
        logic [N_BOTOES-1:0] jog;
        int                  cyc;
    } ev_t;

    logic                clock_in     = 1'b0;
    logic                reset_in     = 1'b0;
    logic [N_BOTOES-1:0] botoes_in    = '1;
    logic                iniciar_in   = 1'b1;
    logic                enable       = 1'b1;
    logic                clear_jogada = 1'b0;
    logic [N_BOTOES-1:0] jogada_out;
    logic                jogada_valid;
    logic                multi_press;
    logic                iniciar_pulse;
    logic [N_BOTOES-1:0] botoes_estaveis;

    int  checks  = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  n_valid = 0;
    int  n_multi = 0;
    int  n_ini   = 0;
    ev_t exp_q[$];
    logic [N_BOTOES-1:0] exp_jog = '0;

    bitbakery_input_conditioner dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .botoes_in      (botoes_in),
        .iniciar_in     (iniciar_in),
        .enable         (enable),
        .clear_jogada   (clear_jogada),
        .jogada_out     (jogada_out),
        .jogada_valid   (jogada_valid),
        .multi_press    (multi_press),
        .iniciar_pulse  (iniciar_pulse),
        .botoes_estaveis(botoes_estaveis)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;

    // Scoreboard: every observed pulse must match the head of the expected queue.
    always @(negedge clock_in) begin : monitor
        logic [2:0] p;
        ev_t        e;
        p = {iniciar_pulse, multi_press, jogada_valid};
        if (jogada_valid)  n_valid++;
        if (multi_press)   n_multi++;
        if (iniciar_pulse) n_ini++;
        for (int k = 0; k < 3; k++) begin
            if (p[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d at cyc=%0d jogada_out=%b, expected no event",
                             k, cyc, jogada_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.cyc != cyc || (k != EV_INI && e.jog !== jogada_out)) begin
                        errors++;
                        $display("FAIL event: got kind=%0d cyc=%0d jogada_out=%b, expected kind=%0d cyc=%0d jogada_out=%b",
                                 k, cyc, jogada_out, e.kind, e.cyc, e.jog);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        step(1);
        reset_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_in);
            checks++;
            if ({jogada_out, jogada_valid, multi_press, iniciar_pulse, botoes_estaveis} !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got outputs=%b, expected all zero", i,
                         {jogada_out, jogada_valid, multi_press, iniciar_pulse, botoes_estaveis});
            end
        end
    endtask

    task automatic test_single_press();
        int v0;
        logic [N_BOTOES-1:0] oh;
        v0 = n_valid;
        for (int i = 0; i < 16; i++) begin
            oh = N_BOTOES'(1) << (i % N_BOTOES);
            botoes_in = ~oh;
            exp_q.push_back(ev_t'{kind: EV_VALID, jog: oh, cyc: cyc + LAT});
            exp_jog = oh;
            step(10);
            checks++;
            if (botoes_estaveis !== oh) begin
                errors++;
                $display("FAIL press_stable %0d: got %b, expected %b", i, botoes_estaveis, oh);
            end
            botoes_in = '1;
            step(12);
            @(negedge clock_in);
            checks++;
            if (jogada_out !== exp_jog || botoes_estaveis !== '0) begin
                errors++;
                $display("FAIL press_held %0d: got jogada_out=%b estaveis=%b, expected %b and 0",
                         i, jogada_out, botoes_estaveis, exp_jog);
            end
        end
        checks++;
        if (n_valid - v0 != 16) begin
            errors++;
            $display("FAIL press_count: got %0d pulses, expected 16", n_valid - v0);
        end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = n_valid;
        botoes_in = 7'b1111101;
        step(2);
        botoes_in = '1;
        step(15);
        botoes_in = 7'b1111011;
        step(3);
        botoes_in = '1;
        step(15);
        checks++;
        if (n_valid != v0 || jogada_out !== exp_jog || botoes_estaveis !== '0) begin
            errors++;
            $display("FAIL glitch_reject: got pulses=%0d jogada_out=%b, expected pulses=%0d jogada_out=%b",
                     n_valid - v0, jogada_out, 0, exp_jog);
        end
        botoes_in = 7'b1111011;
        exp_q.push_back(ev_t'{kind: EV_VALID, jog: 7'b0000100, cyc: cyc + LAT});
        exp_jog = 7'b0000100;
        step(4);
        botoes_in = '1;
        step(15);
        checks++;
        if (n_valid != v0 + 1 || jogada_out !== exp_jog) begin
            errors++;
            $display("FAIL min_pulse_accept: got pulses=%0d jogada_out=%b, expected 1 and %b",
                     n_valid - v0, jogada_out, exp_jog);
        end
    endtask

    task automatic test_multi();
        int v0;
        int m0;
        v0 = n_valid;
        m0 = n_multi;
        botoes_in = 7'b1111100;
        exp_q.push_back(ev_t'{kind: EV_MULTI, jog: exp_jog, cyc: cyc + LAT});
        step(10);
        checks++;
        if (botoes_estaveis !== 7'b0000011) begin
            errors++;
            $display("FAIL multi_stable: got %b, expected 0000011", botoes_estaveis);
        end
        botoes_in = '1;
        step(12);
        checks++;
        if (jogada_out !== exp_jog || n_valid != v0 || n_multi != m0 + 1) begin
            errors++;
            $display("FAIL multi_same_cycle: got jogada_out=%b valid=%0d multi=%0d, expected %b 0 1",
                     jogada_out, n_valid - v0, n_multi - m0, exp_jog);
        end
        botoes_in = 7'b1111011;
        exp_q.push_back(ev_t'{kind: EV_VALID, jog: 7'b0000100, cyc: cyc + LAT});
        exp_jog = 7'b0000100;
        step(10);
        botoes_in = 7'b1101011;
        exp_q.push_back(ev_t'{kind: EV_MULTI, jog: exp_jog, cyc: cyc + LAT});
        step(10);
        botoes_in = '1;
        step(12);
        checks++;
        if (jogada_out !== exp_jog || n_multi != m0 + 2) begin
            errors++;
            $display("FAIL multi_while_held: got jogada_out=%b multi=%0d, expected %b 2",
                     jogada_out, n_multi - m0, exp_jog);
        end
    endtask

    task automatic test_iniciar();
        int i0;
        i0 = n_ini;
        iniciar_in = 1'b0;
        exp_q.push_back(ev_t'{kind: EV_INI, jog: '0, cyc: cyc + LAT});
        step(5);
        iniciar_in = 1'b1;
        step(15);
        checks++;
        if (n_ini != i0 + 1) begin
            errors++;
            $display("FAIL iniciar_short: got %0d pulses, expected 1", n_ini - i0);
        end
        enable = 1'b0;
        iniciar_in = 1'b0;
        exp_q.push_back(ev_t'{kind: EV_INI, jog: '0, cyc: cyc + LAT});
        step(40);
        iniciar_in = 1'b1;
        step(12);
        enable = 1'b1;
        checks++;
        if (n_ini != i0 + 2) begin
            errors++;
            $display("FAIL iniciar_long_hold: got %0d pulses, expected 2", n_ini - i0);
        end
    endtask

    task automatic test_enable_off();
        int v0;
        v0 = n_valid;
        enable = 1'b0;
        botoes_in = 7'b1110111;
        step(10);
        checks++;
        if (botoes_estaveis !== 7'b0001000) begin
            errors++;
            $display("FAIL disabled_debounce: got %b, expected 0001000", botoes_estaveis);
        end
        enable = 1'b1;
        step(10);
        botoes_in = '1;
        step(12);
        checks++;
        if (n_valid != v0 || jogada_out !== exp_jog) begin
            errors++;
            $display("FAIL disabled_press: got pulses=%0d jogada_out=%b, expected 0 and %b",
                     n_valid - v0, jogada_out, exp_jog);
        end
    endtask

    task automatic test_clear();
        clear_jogada = 1'b1;
        step(1);
        clear_jogada = 1'b0;
        exp_jog = '0;
        @(negedge clock_in);
        checks++;
        if (jogada_out !== '0) begin
            errors++;
            $display("FAIL clear: got jogada_out=%b, expected 0000000", jogada_out);
        end
        botoes_in = 7'b1011111;
        exp_q.push_back(ev_t'{kind: EV_VALID, jog: 7'b0100000, cyc: cyc + LAT});
        exp_jog = 7'b0100000;
        step(5);
        clear_jogada = 1'b1;
        step(1);
        clear_jogada = 1'b0;
        @(negedge clock_in);
        checks++;
        if (jogada_out !== exp_jog) begin
            errors++;
            $display("FAIL clear_vs_accept: got jogada_out=%b, expected %b", jogada_out, exp_jog);
        end
        botoes_in = '1;
        step(12);
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = n_valid;
        botoes_in = 7'b1111101;
        step(4);
        reset_in = 1'b0;
        #1;
        checks++;
        if ({jogada_out, jogada_valid, multi_press, iniciar_pulse, botoes_estaveis} !== '0) begin
            errors++;
            $display("FAIL reset_async: got outputs=%b, expected all zero",
                     {jogada_out, jogada_valid, multi_press, iniciar_pulse, botoes_estaveis});
        end
        step(1);
        reset_in = 1'b1;
        exp_q.push_back(ev_t'{kind: EV_VALID, jog: 7'b0000010, cyc: cyc + LAT});
        exp_jog = 7'b0000010;
        step(10);
        botoes_in = '1;
        step(12);
        checks++;
        if (n_valid != v0 + 1 || jogada_out !== exp_jog) begin
            errors++;
            $display("FAIL reset_mid_press: got pulses=%0d jogada_out=%b, expected 1 and %b",
                     n_valid - v0, jogada_out, exp_jog);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_multi();
        test_iniciar();
        test_enable_off();
        test_clear();
        test_reset_mid();
        step(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d expected events never seen, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
